// File: rtl/td4_datapath.sv
// TD4 execute stage: architectural registers A, B, OUT, PC and carry flag,
// with the source mux and adder that feed every destination register.
module td4_datapath #(
    parameter int unsigned      WIDTH    = 4,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [2*WIDTH-1:0] rom_data,
    input  logic [WIDTH-1:0]   in_port,
    input  logic               select_a,
    input  logic               select_b,
    input  logic [3:0]         load,
    output logic [WIDTH-1:0]   op,
    output logic               c_flg,
    output logic [WIDTH-1:0]   pc,
    output logic [WIDTH-1:0]   out_port,
    output logic [WIDTH-1:0]   reg_a,
    output logic [WIDTH-1:0]   reg_b
);

    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] src;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] result;
    logic             carry;

    assign op     = rom_data[2*WIDTH-1:WIDTH];
    assign imm    = rom_data[WIDTH-1:0];
    assign sum    = {1'b0, src} + {1'b0, imm};
    assign result = sum[WIDTH-1:0];
    assign carry  = sum[WIDTH];

    always_comb begin
        src = '0;
        unique case ({select_b, select_a})
            2'b00:   src = reg_a;
            2'b01:   src = reg_b;
            2'b10:   src = in_port;
            default: src = '0;
        endcase
    end

    // Every instruction passes through the adder, so carry is refreshed on
    // each enabled edge regardless of which registers are written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a    <= '0;
            reg_b    <= '0;
            out_port <= '0;
            pc       <= PC_RESET;
            c_flg    <= 1'b0;
        end else if (en) begin
            if (load[0]) reg_a    <= result;
            if (load[1]) reg_b    <= result;
            if (load[2]) out_port <= result;
            pc    <= load[3] ? result : pc + WIDTH'(1);
            c_flg <= carry;
        end
    end

endmodule

// File: tb/tb_td4_datapath.sv
// Self-checking bench for td4_datapath: directed vector table, hand-written
// reset/stepping sequences, then randomized instructions against a model.
module tb_td4_datapath;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] rom_data;
    logic [3:0] in_port;
    logic       select_a;
    logic       select_b;
    logic [3:0] load;
    logic [3:0] op;
    logic       c_flg;
    logic [3:0] pc;
    logic [3:0] out_port;
    logic [3:0] reg_a;
    logic [3:0] reg_b;

    int errors = 0;
    int checks = 0;

    td4_datapath #(.WIDTH(4), .PC_RESET(4'h0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .rom_data (rom_data),
        .in_port  (in_port),
        .select_a (select_a),
        .select_b (select_b),
        .load     (load),
        .op       (op),
        .c_flg    (c_flg),
        .pc       (pc),
        .out_port (out_port),
        .reg_a    (reg_a),
        .reg_b    (reg_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       en;
        bit [1:0] sel;
        bit [3:0] load;
        bit [3:0] imm;
        bit [3:0] inp;
        bit [3:0] ea;
        bit [3:0] eb;
        bit [3:0] eo;
        bit [3:0] ep;
        bit       ec;
    } vec_t;

    vec_t vecs[11];

    // Reference state: index 0=A, 1=B, 2=OUT, 3=PC, matching the load bits.
    int m_reg[4];
    int m_c;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_state(input string tag, input int ea, input int eb, input int eo,
                             input int ep, input int ec);
        chk({tag, ".a"},   reg_a,       4'(ea));
        chk({tag, ".b"},   reg_b,       4'(eb));
        chk({tag, ".out"}, out_port,    4'(eo));
        chk({tag, ".pc"},  pc,          4'(ep));
        chk({tag, ".c"},   4'(c_flg),   4'(ec));
    endtask

    task automatic drive(input bit e, input bit [1:0] s, input bit [3:0] l,
                         input bit [3:0] im, input bit [3:0] inp, input bit [3:0] o);
        en       = e;
        select_b = s[1];
        select_a = s[0];
        load     = l;
        rom_data = {o, im};
        in_port  = inp;
    endtask

    // One instruction from the programmer's view: pick source, add, write all
    // selected registers, PC advances unless it was a destination.
    task automatic model_step(input bit [1:0] s, input bit [3:0] l,
                              input bit [3:0] im, input bit [3:0] inp);
        int src;
        int total;
        int res;
        case (s)
            2'd0:    src = m_reg[0];
            2'd1:    src = m_reg[1];
            2'd2:    src = int'(inp);
            default: src = 0;
        endcase
        total = src + int'(im);
        res   = total % 16;
        m_c   = (total >= 16) ? 1 : 0;
        for (int i = 0; i < 4; i++)
            if (l[i]) m_reg[i] = res;
        if (!l[3]) m_reg[3] = (m_reg[3] + 1) % 16;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            en sel    load     imm    in     A  B  OUT PC  C
        vecs[0]  = '{1, 2'd0, 4'b0001, 4'h3, 4'h0, 3, 0, 0, 1,  0};
        vecs[1]  = '{1, 2'd0, 4'b0001, 4'hF, 4'h0, 2, 0, 0, 2,  1};
        vecs[2]  = '{1, 2'd2, 4'b0100, 4'h1, 4'h6, 2, 0, 7, 3,  0};
        vecs[3]  = '{1, 2'd3, 4'b0011, 4'h5, 4'h0, 5, 5, 7, 4,  0};
        vecs[4]  = '{1, 2'd1, 4'b0001, 4'hC, 4'h0, 1, 5, 7, 5,  1};
        vecs[5]  = '{0, 2'd0, 4'b1111, 4'hF, 4'h0, 1, 5, 7, 5,  1};
        vecs[6]  = '{1, 2'd3, 4'b1000, 4'hE, 4'h0, 1, 5, 7, 14, 0};
        vecs[7]  = '{1, 2'd0, 4'b0000, 4'h0, 4'h0, 1, 5, 7, 15, 0};
        vecs[8]  = '{1, 2'd0, 4'b0000, 4'h0, 4'h0, 1, 5, 7, 0,  0};
        vecs[9]  = '{1, 2'd3, 4'b1000, 4'hA, 4'h0, 1, 5, 7, 10, 0};
        vecs[10] = '{1, 2'd0, 4'b0000, 4'hF, 4'h0, 1, 5, 7, 11, 1};

        rst_n = 1'b0;
        drive(0, 2'd0, 4'b0000, 4'h0, 4'h0, 4'h0);
        #1;
        chk_state("reset_init", 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(vecs[i].en, vecs[i].sel, vecs[i].load, vecs[i].imm, vecs[i].inp, 4'(i + 3));
            #1 chk($sformatf("vec%0d.op", i), op, 4'(i + 3));
            @(posedge clk);
            #1 chk_state($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].eo,
                         vecs[i].ep, vecs[i].ec);
        end

        // Async reset mid-cycle with non-zero state, then an edge while held.
        drive(1, 2'd3, 4'b1111, 4'h9, 4'h0, 4'h0);
        #2 rst_n = 1'b0;
        #1 chk_state("async_rst", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 chk_state("rst_hold_edge", 0, 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;

        // Stepping: five disabled edges, one enabled, one more disabled.
        drive(0, 2'd0, 4'b0001, 4'h3, 4'h0, 4'h5);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1 chk_state($sformatf("hold%0d", k), 0, 0, 0, 0, 0);
        end
        chk("hold.op", op, 4'h5);
        @(negedge clk) en = 1'b1;
        @(posedge clk);
        #1 chk_state("step1", 3, 0, 0, 1, 0);
        @(negedge clk) en = 1'b0;
        @(posedge clk);
        #1 chk_state("step_hold", 3, 0, 0, 1, 0);

        m_reg[0] = 3; m_reg[1] = 0; m_reg[2] = 0; m_reg[3] = 1; m_c = 0;
        for (int n = 0; n < 400; n++) begin
            bit       e;
            bit [1:0] s;
            bit [3:0] l;
            bit [3:0] im;
            bit [3:0] inp;
            bit [3:0] o;
            e   = ($urandom_range(0, 7) != 0);
            s   = 2'($urandom);
            l   = 4'($urandom);
            im  = 4'($urandom);
            inp = 4'($urandom);
            o   = 4'($urandom);
            @(negedge clk);
            drive(e, s, l, im, inp, o);
            #1 chk("rnd.op", op, o);
            if (e) model_step(s, l, im, inp);
            @(posedge clk);
            #1 chk_state($sformatf("rnd%0d", n), m_reg[0], m_reg[1], m_reg[2], m_reg[3], m_c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/td4_datapath.md
Name: td4_datapath

Overview:
- Execute stage of the TD4 4-bit CPU, directly downstream of op_decoder.
- Holds the architectural state: registers A, B, OUT, PC and the carry flag.
- Drives the ROM address and returns op and c_flg to op_decoder.
- Consumes select_a, select_b and load from op_decoder to pick the ALU source and the destination register each instruction cycle.

Parameters:
- WIDTH, 4, data/register/immediate width in bits; ROM word is 2*WIDTH.
- PC_RESET, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  step enable; state updates only on rising clk with en=1 (manual/slow-clock stepping).
- rom_data  input  2*WIDTH  instruction at address pc; combinational ROM; [7:4]=op, [3:0]=imm.
- in_port  input  WIDTH  external input switches.
- select_a  input  1  ALU source select LSB, from op_decoder.
- select_b  input  1  ALU source select MSB, from op_decoder.
- load  input  4  active-high destination enables, from op_decoder: [0]=A, [1]=B, [2]=OUT, [3]=PC.
- op  output  4  rom_data[7:4], combinational pass-through to op_decoder.
- c_flg  output  1  registered carry flag, to op_decoder.
- pc  output  WIDTH  ROM address.
- out_port  output  WIDTH  OUT register.
- reg_a  output  WIDTH  A register, debug visibility.
- reg_b  output  WIDTH  B register, debug visibility.

Behaviour:
- Reset (rst_n=0, asynchronous, no clock needed): A=B=OUT=0, pc=PC_RESET, c_flg=0. All outputs reflect this while rst_n is low.
- Reset deassertion is synchronised by the user; the first update occurs on the first rising clk with rst_n=1 and en=1.
- Source mux on {select_b,select_a}: 00 -> A, 01 -> B, 10 -> in_port, 11 -> zero.
- Adder: sum[WIDTH:0] = zero-extended mux + zero-extended imm. Result = sum[WIDTH-1:0]; carry = sum[WIDTH]. Wraps mod 2^WIDTH.
- Single-cycle execution, one instruction per enabled rising edge:
  - For each i with load[i]=1, the destination register <= result.
  - Multiple load bits set: every selected register is written with the same result. Not an error.
  - load=0000: no register write except PC increment.
- PC update: load[3]=1 -> pc <= result; otherwise pc <= pc+1, wrapping 15 -> 0.
- c_flg <= carry on every enabled edge, including jumps, OUT and MOV (all go through the adder).
  - The decoder therefore sees the carry of the previous instruction (JNC semantics).
- en=0: all state holds; combinational outputs (op) still track rom_data.
- No internal FSM beyond the register set; latency from instruction fetch to architectural update is exactly 1 enabled clock.
- Reset asserted mid-program: immediate clear of all state; any pending edge is ignored while rst_n=0.
- X/Z on select or load inputs: not guarded; the bench must not drive them.

Test Plan:
- Reset: pulse rst_n low mid-cycle with registers non-zero -> A=B=OUT=pc=0 and c_flg=0 immediately, without a clock edge.
- ADD A,Im: rom_data=0000_0011 (sel=00, load=0001) with A=0 -> after 1 edge A=3, pc=1, c_flg=0. Repeat with imm=1111 and A=3 -> A=2, c_flg=1.
- JMP wrap:
  - At pc=14 with load=0000 -> pc=15.
  - Next edge with load=0000 -> pc=0.
  - JMP imm=1010 (sel=11, load=1000) -> pc=10, c_flg=0.
- IN/OUT: in_port=0110, sel=10, load=0100, imm=0001 -> out_port=0111 after 1 edge; A and B unchanged.
- Stepping: en=0 for 5 clocks with a load=0001 instruction present -> no state change. Raise en for 1 clock -> exactly one update.
- Multi-load: sel=11, load=0011, imm=0101 -> A=B=5, pc incremented by 1.
